cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 125 ++++++++++++
 tb/tb_cdb_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that lets NUM_REQ functional units share one common data bus (CDB).
// Optional macro CDB_OUT_REG_EN registers the CDB outputs one cycle after the grant.
`ifndef ROB_SIZE
`define ROB_SIZE 6
`endif

module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = `ROB_SIZE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_value_i,
  input  logic [NUM_REQ-1:0]          req_br_taken_i,
  input  logic                        flush_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic                        cdb_valid_o,
  output logic [TAG_W-1:0]            cdb_tag_o,
  output logic [DATA_W-1:0]           cdb_value_o,
  output logic                        cdb_br_taken_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  last_q, last_d;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [PTR_W-1:0]  cand;

  logic [TAG_W-1:0]  tag_sel,   tag_q,   tag_d;
  logic [DATA_W-1:0] value_sel, value_q, value_d;
  logic              br_sel,    br_q,    br_d;

  // Search starts one past the last winner; rst_n gates the grant so reset clears it at once.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (rst_n && !flush_i) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand = PTR_W'((int'(last_q) + i) % NUM_REQ);
        if (!gnt_any && req_i[cand]) begin
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
          gnt_any   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    tag_sel   = '0;
    value_sel = '0;
    br_sel    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        tag_sel   = tag_sel   | req_tag_i[k*TAG_W +: TAG_W];
        value_sel = value_sel | req_value_i[k*DATA_W +: DATA_W];
        br_sel    = br_sel    | req_br_taken_i[k];
      end
    end
  end

  // Payload registers remember the last broadcast so an idle bus keeps showing it.
  always_comb begin
    last_d  = last_q;
    tag_d   = tag_q;
    value_d = value_q;
    br_d    = br_q;
    if (gnt_any) begin
      last_d  = gnt_idx;
      tag_d   = tag_sel;
      value_d = value_sel;
      br_d    = br_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= PTR_W'(NUM_REQ - 1);
      tag_q   <= '0;
      value_q <= '0;
      br_q    <= 1'b0;
    end else begin
      last_q  <= last_d;
      tag_q   <= tag_d;
      value_q <= value_d;
      br_q    <= br_d;
    end
  end

  assign gnt_o = gnt;

`ifdef CDB_OUT_REG_EN
  logic valid_q, valid_d;

  always_comb begin
    valid_d = gnt_any && !flush_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign cdb_valid_o    = valid_q;
  assign cdb_tag_o      = tag_q;
  assign cdb_value_o    = value_q;
  assign cdb_br_taken_o = br_q;
`else
  assign cdb_valid_o    = gnt_any;
  assign cdb_tag_o      = gnt_any ? tag_sel   : tag_q;
  assign cdb_value_o    = gnt_any ? value_sel : value_q;
  assign cdb_br_taken_o = gnt_any ? br_sel    : br_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized checks for cdb_arbiter; inputs change on negedge, outputs sampled 1ns later.
`timescale 1ns/1ps

module tb_cdb_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TW   = 6;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_i;
  logic [NREQ*TW-1:0]   req_tag_i;
  logic [NREQ*DW-1:0]   req_value_i;
  logic [NREQ-1:0]      req_br_taken_i;
  logic                 flush_i;
  logic [NREQ-1:0]      gnt_o;
  logic                 cdb_valid_o;
  logic [TW-1:0]        cdb_tag_o;
  logic [DW-1:0]        cdb_value_o;
  logic                 cdb_br_taken_o;

  int checks;
  int failures;

  cdb_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .req_tag_i      (req_tag_i),
    .req_value_i    (req_value_i),
    .req_br_taken_i (req_br_taken_i),
    .flush_i        (flush_i),
    .gnt_o          (gnt_o),
    .cdb_valid_o    (cdb_valid_o),
    .cdb_tag_o      (cdb_tag_o),
    .cdb_value_o    (cdb_value_o),
    .cdb_br_taken_o (cdb_br_taken_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; req_i = 4'b1111;
    req_tag_i = '1; req_value_i = '1; req_br_taken_i = '1;
    #2;
    checks++; if (gnt_o !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt_o); end
    checks++; if (cdb_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cdb_valid_o); end
    checks++; if (cdb_tag_o !== '0) begin failures++; $display("FAIL reset_tag got=%h exp=0", cdb_tag_o); end
    checks++; if (cdb_value_o !== '0) begin failures++; $display("FAIL reset_value got=%h exp=0", cdb_value_o); end
    checks++; if (cdb_br_taken_o !== 1'b0) begin failures++; $display("FAIL reset_br got=%b exp=0", cdb_br_taken_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; req_i = '0; req_tag_i = '0; req_value_i = '0; req_br_taken_i = '0;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp;
    req_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp = 4'b0001 << (i % 4);
      #1;
      checks++; if (gnt_o !== exp) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, gnt_o, exp); end
      @(negedge clk);
    end
    req_i = '0;
  endtask

  task automatic test_payload();
    req_i = 4'b0100;
    req_tag_i = {TW'(9), TW'(5), TW'(3), TW'(1)};
    req_value_i = {32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333};
    req_br_taken_i = 4'b0100;
    #1;
    checks++; if (gnt_o !== 4'b0100) begin failures++; $display("FAIL pay_gnt got=%b exp=0100", gnt_o); end
`ifdef CDB_OUT_REG_EN
    @(negedge clk);
    req_i = '0; req_tag_i = '0; req_value_i = '0; req_br_taken_i = '0;
    #1;
`endif
    checks++; if (cdb_valid_o !== 1'b1) begin failures++; $display("FAIL pay_valid got=%b exp=1", cdb_valid_o); end
    checks++; if (cdb_tag_o !== TW'(5)) begin failures++; $display("FAIL pay_tag got=%h exp=5", cdb_tag_o); end
    checks++; if (cdb_value_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL pay_value got=%h exp=deadbeef", cdb_value_o); end
    checks++; if (cdb_br_taken_o !== 1'b1) begin failures++; $display("FAIL pay_br got=%b exp=1", cdb_br_taken_o); end
    @(negedge clk);
    req_i = '0; req_tag_i = '0; req_value_i = '0; req_br_taken_i = '0;
    #1;
    checks++; if (gnt_o !== 4'b0000) begin failures++; $display("FAIL idle_gnt got=%b exp=0000", gnt_o); end
    checks++; if (cdb_valid_o !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", cdb_valid_o); end
    checks++; if (cdb_tag_o !== TW'(5)) begin failures++; $display("FAIL idle_tag_hold got=%h exp=5", cdb_tag_o); end
    checks++; if (cdb_value_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL idle_value_hold got=%h exp=deadbeef", cdb_value_o); end
    checks++; if (cdb_br_taken_o !== 1'b1) begin failures++; $display("FAIL idle_br_hold got=%b exp=1", cdb_br_taken_o); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    req_i = 4'b1000;
    #1;
    checks++; if (gnt_o !== 4'b1000) begin failures++; $display("FAIL wrap_g3 got=%b exp=1000", gnt_o); end
    @(negedge clk);
    req_i = 4'b1001;
    #1;
    checks++; if (gnt_o !== 4'b0001) begin failures++; $display("FAIL wrap_g0 got=%b exp=0001", gnt_o); end
    @(negedge clk);
    #1;
    checks++; if (gnt_o !== 4'b1000) begin failures++; $display("FAIL wrap_g3b got=%b exp=1000", gnt_o); end
    @(negedge clk);
    req_i = '0;
  endtask

  task automatic test_flush();
    req_i = 4'b1111; flush_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (gnt_o !== 4'b0000) begin failures++; $display("FAIL flush_gnt[%0d] got=%b exp=0000", i, gnt_o); end
      checks++; if (cdb_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid[%0d] got=%b exp=0", i, cdb_valid_o); end
      @(negedge clk);
    end
    flush_i = 1'b0;
    #1;
    checks++; if (gnt_o !== 4'b0001) begin failures++; $display("FAIL flush_resume0 got=%b exp=0001", gnt_o); end
    @(negedge clk);
    #1;
    checks++; if (gnt_o !== 4'b0010) begin failures++; $display("FAIL flush_resume1 got=%b exp=0010", gnt_o); end
    @(negedge clk);
    req_i = '0;
  endtask

  task automatic test_back_to_back();
    req_i = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      req_tag_i = '0;
      req_tag_i[TW +: TW] = TW'(i + 1);
      #1;
      checks++; if (gnt_o !== 4'b0010) begin failures++; $display("FAIL b2b_gnt[%0d] got=%b exp=0010", i, gnt_o); end
`ifdef CDB_OUT_REG_EN
      if (i > 0) begin
        checks++; if (cdb_tag_o !== TW'(i)) begin failures++; $display("FAIL b2b_tag[%0d] got=%h exp=%h", i, cdb_tag_o, TW'(i)); end
      end
`else
      checks++; if (cdb_tag_o !== TW'(i + 1)) begin failures++; $display("FAIL b2b_tag[%0d] got=%h exp=%h", i, cdb_tag_o, TW'(i + 1)); end
`endif
      @(negedge clk);
    end
    req_i = '0; req_tag_i = '0;
  endtask

  task automatic test_reset_mid();
    req_i = 4'b0001;
    req_tag_i = '0; req_tag_i[0 +: TW] = TW'(7);
    #1;
    checks++; if (gnt_o !== 4'b0001) begin failures++; $display("FAIL rmid_gnt got=%b exp=0001", gnt_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (gnt_o !== 4'b0000) begin failures++; $display("FAIL rmid_gnt_clr got=%b exp=0000", gnt_o); end
    checks++; if (cdb_valid_o !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", cdb_valid_o); end
    checks++; if (cdb_tag_o !== '0) begin failures++; $display("FAIL rmid_tag got=%h exp=0", cdb_tag_o); end
    @(posedge clk);
    #1;
    checks++; if (cdb_valid_o !== 1'b0) begin failures++; $display("FAIL rmid_nowrite got=%b exp=0", cdb_valid_o); end
    @(negedge clk);
    rst_n = 1'b1; req_i = 4'b1010; req_tag_i = '0;
    #1;
    checks++; if (gnt_o !== 4'b0010) begin failures++; $display("FAIL rmid_first got=%b exp=0010", gnt_o); end
    @(negedge clk);
    req_i = '0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pending, exp;
    int mptr, gidx, ix;
    int waits [NREQ];
    bit found;
    pending = '0;
    mptr = NREQ - 1;
    for (int k = 0; k < NREQ; k++) waits[k] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < NREQ; k++)
        if (!pending[k]) pending[k] = ($urandom_range(0, 2) == 0);
      req_i = pending;
      req_tag_i = NREQ*TW'($urandom);
      req_value_i = {$urandom, $urandom, $urandom, $urandom};
      req_br_taken_i = NREQ'($urandom);
      exp = '0; found = 1'b0; gidx = 0;
      for (int o = 1; o <= NREQ; o++) begin
        ix = (mptr + o) % NREQ;
        if (!found && pending[ix]) begin exp[ix] = 1'b1; found = 1'b1; gidx = ix; end
      end
      #1;
      checks++; if (gnt_o !== exp) begin failures++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", c, gnt_o, exp); end
      checks++; if (!$onehot0(gnt_o) || ((gnt_o & ~req_i) != '0)) begin failures++; $display("FAIL rand_live[%0d] got=%b req=%b", c, gnt_o, req_i); end
      if (found) begin
        mptr = gidx;
        pending[gidx] = 1'b0;
        waits[gidx] = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (pending[k]) begin
            waits[k]++;
            checks++; if (waits[k] > NREQ - 1) begin failures++; $display("FAIL rand_wait[%0d] req%0d got=%0d max=%0d", c, k, waits[k], NREQ - 1); end
          end
        end
      end
      @(negedge clk);
    end
    req_i = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_round_robin();
    test_payload();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
